// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the CPU's single memory port between the instruction-fetch requester
// and the load/store requester. Each access is one strobe, held until the
// memory answers with inputReady or the wait timeout expires. The access then
// finishes with a one-cycle DONE state that carries the requester's ack (and
// err on timeout). The next IDLE cycle can grant again, so strobes are always
// separated by at least two low cycles.
//
// Ports:
//   clk, reset_n                  clock (rising edge), async active-low reset
//   if_req/if_addr                fetch request (level) and address
//   if_ack/if_rdata               fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata     data request (level), 1 = store, address, store data
//   d_ack/d_rdata                 data completion pulse and load result
//   err                           high with the ack of an access that timed out
//   readM/writeM/address/data_out memory strobes, address and write data
//   data_in/inputReady            memory read data and completion
//   fetch_count                   number of successful fetches (wraps)
module mem_port_arbiter #(
   parameter int WORD_SIZE      = 16,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int STARVE_LIMIT   = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 if_req,
   input  logic [WORD_SIZE-1:0] if_addr,
   output logic                 if_ack,
   output logic [WORD_SIZE-1:0] if_rdata,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [WORD_SIZE-1:0] d_addr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic                 d_ack,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 err,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   output logic [WORD_SIZE-1:0] data_out,
   input  logic [WORD_SIZE-1:0] data_in,
   input  logic                 inputReady,
   output logic [WORD_SIZE-1:0] fetch_count
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, DONE} state_t;

   state_t               state_reg, state_next;
   logic [WORD_SIZE-1:0] address_reg, data_out_reg, if_rdata_reg, d_rdata_reg;
   logic [WORD_SIZE-1:0] fetch_count_reg;
   logic [TW-1:0]        tmo_reg;
   logic [SW-1:0]        starve_reg;
   logic                 err_reg;
   logic                 ack_data_reg;   // 1: current access belongs to the data requester

   logic wait_state, complete, timed_out, grant_fetch, grant_data, fetch_forced;

   // Grant and completion decode shared by the next-state and datapath logic.
   always_comb begin
      wait_state   = (state_reg == FETCH) || (state_reg == LOAD) || (state_reg == STORE);
      complete     = wait_state && inputReady;
      // inputReady on the expiry edge wins, so expiry requires !inputReady.
      timed_out    = wait_state && !inputReady && (tmo_reg == TMO_LAST);
      fetch_forced = if_req && (starve_reg == STARVE_MAX);
      grant_fetch  = (state_reg == IDLE) && if_req && (fetch_forced || !d_req);
      grant_data   = (state_reg == IDLE) && d_req && !fetch_forced;
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (grant_fetch)     state_next = FETCH;
            else if (grant_data) state_next = d_we ? STORE : LOAD;
         end
         FETCH, LOAD, STORE: begin
            if (complete || timed_out) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: strobes and acks are pure state decodes, so reset clears
   // them the moment reset_n falls.
   always_comb begin
      readM  = (state_reg == FETCH) || (state_reg == LOAD);
      writeM = (state_reg == STORE);
      if_ack = (state_reg == DONE) && !ack_data_reg;
      d_ack  = (state_reg == DONE) && ack_data_reg;
      err    = (state_reg == DONE) && err_reg;
   end

   // Datapath: latched request, wait/starve counters, read-data capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         address_reg     <= '0;
         data_out_reg    <= '0;
         if_rdata_reg    <= '0;
         d_rdata_reg     <= '0;
         fetch_count_reg <= '0;
         tmo_reg         <= '0;
         starve_reg      <= '0;
         err_reg         <= 1'b0;
         ack_data_reg    <= 1'b0;
      end else begin
         if (grant_fetch) begin
            address_reg  <= if_addr;
            ack_data_reg <= 1'b0;
            tmo_reg      <= '0;
            starve_reg   <= '0;
         end else if (grant_data) begin
            address_reg  <= d_addr;
            ack_data_reg <= 1'b1;
            tmo_reg      <= '0;
            if (d_we) data_out_reg <= d_wdata;
            // Count data grants that made a waiting fetch stand aside.
            if (!if_req)                      starve_reg <= '0;
            else if (starve_reg < STARVE_MAX) starve_reg <= starve_reg + 1'b1;
         end

         if (complete) begin
            err_reg <= 1'b0;
            if (state_reg == FETCH) begin
               if_rdata_reg    <= data_in;
               fetch_count_reg <= fetch_count_reg + 1'b1;
            end else if (state_reg == LOAD) begin
               d_rdata_reg <= data_in;
            end
         end else if (timed_out) begin
            err_reg <= 1'b1;
         end else if (wait_state) begin
            tmo_reg <= tmo_reg + 1'b1;
         end
      end
   end

   assign address     = address_reg;
   assign data_out    = data_out_reg;
   assign if_rdata    = if_rdata_reg;
   assign d_rdata     = d_rdata_reg;
   assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        if_req, d_req, d_we, inputReady;
   logic [15:0] if_addr, d_addr, d_wdata, data_in;
   logic        if_ack, d_ack, err, readM, writeM;
   logic [15:0] if_rdata, d_rdata, address, data_out, fetch_count;

   // Narrow instance used to reach the fetch_count wrap in a short run.
   logic       s_if_req;
   logic [3:0] s_zero = 4'h0;
   logic [3:0] s_data_in = 4'h9;
   logic       s_if_ack, s_d_ack, s_err, s_readM, s_writeM;
   logic [3:0] s_if_rdata, s_d_rdata, s_address, s_data_out, s_fetch_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.WORD_SIZE(16), .TIMEOUT_CYCLES(64), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
      .readM(readM), .writeM(writeM), .address(address), .data_out(data_out),
      .data_in(data_in), .inputReady(inputReady), .fetch_count(fetch_count)
   );

   mem_port_arbiter #(.WORD_SIZE(4), .TIMEOUT_CYCLES(4), .STARVE_LIMIT(1)) dut_small (
      .clk(clk), .reset_n(reset_n),
      .if_req(s_if_req), .if_addr(s_zero), .if_ack(s_if_ack), .if_rdata(s_if_rdata),
      .d_req(1'b0), .d_we(1'b0), .d_addr(s_zero), .d_wdata(s_zero),
      .d_ack(s_d_ack), .d_rdata(s_d_rdata), .err(s_err),
      .readM(s_readM), .writeM(s_writeM), .address(s_address), .data_out(s_data_out),
      .data_in(s_data_in), .inputReady(1'b1), .fetch_count(s_fetch_count)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   int          n, g, low, min_gap, overlap, acks, seen;
   logic [9:0]  seq;

   initial begin
      reset_n = 1'b0; s_if_req = 1'b0;
      if_req = 0; d_req = 0; d_we = 0; inputReady = 0;
      if_addr = 0; d_addr = 0; d_wdata = 0; data_in = 0;

      // Reset state
      tick();
      chk("rst_readM", readM, 0);
      chk("rst_writeM", writeM, 0);
      chk("rst_address", address, 0);
      chk("rst_acks", {if_ack, d_ack, err}, 0);
      chk("rst_fetch_count", fetch_count, 0);
      chk("rst_rdata", {if_rdata, d_rdata}, 0);
      reset_n = 1'b1;
      tick();

      // Fetch: strobe one cycle after request, ready on the second strobe cycle
      if_req = 1; if_addr = 16'h0010;
      tick();
      chk("f_readM", readM, 1);
      chk("f_address", address, 16'h0010);
      tick();
      chk("f_readM_hold", readM, 1);
      inputReady = 1; data_in = 16'hA3B4;
      tick();
      chk("f_if_ack", if_ack, 1);
      chk("f_if_rdata", if_rdata, 16'hA3B4);
      chk("f_fetch_count", fetch_count, 1);
      chk("f_readM_low_in_ack", readM, 0);
      chk("f_err", err, 0);
      if_req = 0; inputReady = 0; data_in = 16'h0000;
      tick();
      chk("f_ack_pulse", if_ack, 0);

      // Store with data change after grant (must stay latched)
      d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h5678;
      tick();
      chk("s_writeM", writeM, 1);
      chk("s_readM", readM, 0);
      chk("s_address", address, 16'h0200);
      chk("s_data_out", data_out, 16'h5678);
      d_wdata = 16'h1111;
      tick();
      chk("s_data_out_latched", data_out, 16'h5678);
      inputReady = 1;
      tick();
      chk("s_d_ack", d_ack, 1);
      chk("s_err", err, 0);
      chk("s_writeM_low", writeM, 0);
      chk("s_d_rdata_unchanged", d_rdata, 0);
      d_req = 0; inputReady = 0;
      tick();

      // Load to give d_rdata a known value
      d_req = 1; d_we = 0; d_addr = 16'h0250; inputReady = 1; data_in = 16'h0BEE;
      tick();
      chk("l_readM", readM, 1);
      tick();
      chk("l_d_ack", d_ack, 1);
      chk("l_d_rdata", d_rdata, 16'h0BEE);
      d_req = 0; inputReady = 0; data_in = 16'hDEAD;
      tick();

      // Load that never gets inputReady: 64 strobe cycles then err ack
      d_req = 1; d_addr = 16'h0260;
      n = 0;
      for (int t = 0; t < 200; t++) begin
         tick();
         if (readM) n++;
         else break;
      end
      chk("to_readM_cycles", n, 64);
      chk("to_d_ack", d_ack, 1);
      chk("to_err", err, 1);
      chk("to_d_rdata_kept", d_rdata, 16'h0BEE);
      d_req = 0;
      tick();
      chk("to_err_pulse", err, 0);

      // Both requesters held, memory always ready: D,D,D,D,F,D,D,D,D,F
      if_req = 1; if_addr = 16'h0100; d_req = 1; d_we = 0; d_addr = 16'h0300;
      inputReady = 1; data_in = 16'h2222;
      g = 0; low = 0; min_gap = 99; overlap = 0; seen = 0; seq = '0;
      for (int t = 0; t < 100 && g < 10; t++) begin
         tick();
         if (readM && writeM) overlap++;
         if (readM || writeM) begin
            if (seen != 0 && low < min_gap) min_gap = low;
            seen = 1; low = 0;
            seq[g] = (address == 16'h0100);
            g++;
         end else begin
            low++;
         end
      end
      if_req = 0; d_req = 0;
      chk("arb_grants", g, 10);
      chk("arb_order", seq, 10'b10_0001_0000);
      chk("arb_min_gap", min_gap, 2);
      chk("arb_overlap", overlap, 0);
      tick();
      tick();
      chk("arb_fetch_count", fetch_count, 3);
      inputReady = 0;

      // Reset in the middle of a load
      d_req = 1; d_addr = 16'h0400;
      tick();
      chk("r_readM_before", readM, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("r_readM_async", readM, 0);
      chk("r_address_async", address, 0);
      chk("r_acks_async", {if_ack, d_ack}, 0);
      d_req = 0;
      tick();
      reset_n = 1'b1;
      n = 0;
      for (int t = 0; t < 5; t++) begin
         tick();
         if (readM || d_ack || if_ack) n++;
      end
      chk("r_no_activity", n, 0);
      if_req = 1; if_addr = 16'h0000;
      tick();
      chk("r_fetch_readM", readM, 1);
      chk("r_fetch_address", address, 0);
      inputReady = 1; data_in = 16'h1234;
      tick();
      chk("r_fetch_ack", if_ack, 1);
      chk("r_fetch_rdata", if_rdata, 16'h1234);
      chk("r_fetch_count", fetch_count, 1);
      if_req = 0; inputReady = 0;
      tick();

      // fetch_count wrap on the 4-bit instance: 15 then 0
      s_if_req = 1;
      acks = 0;
      for (int t = 0; t < 200 && acks < 16; t++) begin
         tick();
         if (s_if_ack) begin
            acks++;
            if (acks == 15) chk("wrap_count_max", s_fetch_count, 4'hF);
            if (acks == 16) chk("wrap_count_zero", s_fetch_count, 4'h0);
         end
      end
      s_if_req = 0;
      chk("wrap_acks", acks, 16);
      chk("wrap_rdata", s_if_rdata, 4'h9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
